// File: rtl/core0_fetch.sv
// core0 instruction-byte prefetch stage.
// Streams program bytes into a small FIFO ahead of the decoder.
module core0_fetch #(
  parameter int PROGRAM_ADDR_WIDTH = 1,
  parameter int FETCH_DEPTH = 4,
  parameter logic [PROGRAM_ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [PROGRAM_ADDR_WIDTH-1:0] programmem_addr,
  input  logic [7:0]                    programmem_read_value,
  input  logic                          jump,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] jump_addr,
  input  logic                          consume,
  output logic [7:0]                    out_byte,
  output logic [PROGRAM_ADDR_WIDTH-1:0] out_pc,
  output logic                          out_valid,
  output logic [$clog2(FETCH_DEPTH):0]  level
);

  localparam int AW = PROGRAM_ADDR_WIDTH;
  localparam int PW = $clog2(FETCH_DEPTH);
  localparam int LW = PW + 1;
  localparam int OW = LW + 1;

  typedef struct packed {
    logic [7:0]    b;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t        fifo [FETCH_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level_q;
  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] issue_addr;
  logic          issued;

  logic          pop;
  logic          push;
  logic          issue;
  logic [OW-1:0] occ;

  assign out_valid = (level_q != '0);
  assign pop       = consume && out_valid;
  assign push      = issued && !jump;

  // The in-flight byte already owns a slot; a pop this cycle frees one.
  assign occ   = OW'(level_q) + OW'(issued) - OW'(pop);
  assign issue = !jump && (occ < OW'(FETCH_DEPTH));

  assign programmem_addr = fetch_addr;
  assign out_byte        = fifo[rd_ptr].b;
  assign out_pc          = fifo[rd_ptr].pc;
  assign level           = level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        fifo[i] <= '0;
      end
    end else if (push) begin
      fifo[wr_ptr] <= '{b: programmem_read_value, pc: issue_addr};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level_q    <= '0;
      fetch_addr <= RESET_ADDR;
      issue_addr <= RESET_ADDR;
      issued     <= 1'b0;
    end else if (jump) begin
      rd_ptr     <= wr_ptr;
      level_q    <= '0;
      issued     <= 1'b0;
      fetch_addr <= jump_addr;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (issue) begin
        issued     <= 1'b1;
        issue_addr <= fetch_addr;
        fetch_addr <= fetch_addr + AW'(1);
      end else begin
        issued <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core0_fetch.sv
// Testbench for core0_fetch.
// Queue-based stream model plus directed scenarios and a random run.
module tb_core0_fetch;

  localparam int AW = 8;
  localparam int D  = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] pm_addr;
  logic [7:0]    pm_rdata;
  logic          jump = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic          consume = 1'b0;
  logic [7:0]    out_byte;
  logic [AW-1:0] out_pc;
  logic          out_valid;
  logic [LW-1:0] level;

  logic [3:0]    pm_addr4;
  logic [7:0]    pm_rdata4;
  logic          jump4 = 1'b0;
  logic [3:0]    jump_addr4 = '0;
  logic          consume4 = 1'b0;
  logic [7:0]    out_byte4;
  logic [3:0]    out_pc4;
  logic          out_valid4;
  logic [2:0]    level4;

  logic [7:0] mem [256];

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] q [$];
  bit            m_infl;
  logic [AW-1:0] m_infl_addr;
  logic [AW-1:0] m_next;

  core0_fetch #(
    .PROGRAM_ADDR_WIDTH(AW),
    .FETCH_DEPTH(D),
    .RESET_ADDR(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .programmem_addr(pm_addr),
    .programmem_read_value(pm_rdata),
    .jump(jump),
    .jump_addr(jump_addr),
    .consume(consume),
    .out_byte(out_byte),
    .out_pc(out_pc),
    .out_valid(out_valid),
    .level(level)
  );

  core0_fetch #(
    .PROGRAM_ADDR_WIDTH(4),
    .FETCH_DEPTH(4),
    .RESET_ADDR(4'h0)
  ) dut4 (
    .clk(clk),
    .reset(reset),
    .programmem_addr(pm_addr4),
    .programmem_read_value(pm_rdata4),
    .jump(jump4),
    .jump_addr(jump_addr4),
    .consume(consume4),
    .out_byte(out_byte4),
    .out_pc(out_pc4),
    .out_valid(out_valid4),
    .level(level4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pm_rdata <= mem[pm_addr];
  always @(posedge clk) pm_rdata4 <= {4'h0, pm_addr4} + 8'h10;

  task automatic model_reset();
    q.delete();
    m_infl = 1'b0;
    m_next = '0;
  endtask

  // Drive one cycle and advance the reference stream model.
  task automatic step(input bit c, input bit j, input logic [AW-1:0] ja);
    bit pop;
    int occ;
    consume   = c;
    jump      = j;
    jump_addr = ja;
    pop = c && (q.size() > 0);
    if (j) begin
      q.delete();
      m_infl = 1'b0;
      m_next = ja;
    end else begin
      occ = q.size() + int'(m_infl) - int'(pop);
      if (pop) void'(q.pop_front());
      if (m_infl) q.push_back(m_infl_addr);
      if (occ < D) begin
        m_infl      = 1'b1;
        m_infl_addr = m_next;
        m_next      = m_next + 8'd1;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    consume = 1'b0;
    jump    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    consume = 1'b0;
    jump = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (level !== 3'd0) begin
      failures++;
      $display("FAIL reset_level got=%0d exp=0", level);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_byte !== 8'h00 || out_pc !== 8'h00) begin
      failures++;
      $display("FAIL reset_head got=%h/%h exp=00/00", out_byte, out_pc);
    end
    checks++;
    if (pm_addr !== 8'h00) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=00", pm_addr);
    end
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    checks++;
    if (level !== 3'd4) begin
      failures++;
      $display("FAIL fill_level got=%0d exp=4", level);
    end
    checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'h10 || out_pc !== 8'h00) begin
      failures++;
      $display("FAIL fill_head got=%b/%h/%h exp=1/10/00",
               out_valid, out_byte, out_pc);
    end
    checks++;
    if (pm_addr !== 8'h04) begin
      failures++;
      $display("FAIL fill_addr got=%h exp=04", pm_addr);
    end
    checks++;
    if (level4 !== 3'd4) begin
      failures++;
      $display("FAIL fill_level4 got=%0d exp=4", level4);
    end
  endtask

  task automatic test_stream();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_c0 got=%b exp=0", out_valid);
    end
    step(1'b1, 1'b0, '0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_c1 got=%b exp=0", out_valid);
    end
    step(1'b1, 1'b0, '0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00) begin
      failures++;
      $display("FAIL stream_c2 got=%b/%h exp=1/00", out_valid, out_pc);
    end
    for (int k = 1; k < 16; k++) begin
      step(1'b1, 1'b0, '0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'(k) ||
          out_byte !== mem[k]) begin
        failures++;
        $display("FAIL stream_seq got=%b/%h/%h exp=1/%h/%h",
                 out_valid, out_pc, out_byte, 8'(k), mem[k]);
      end
    end
  endtask

  task automatic test_jump();
    bit seen;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    checks++;
    if (level !== 3'd3) begin
      failures++;
      $display("FAIL jump_pre_level got=%0d exp=3", level);
    end
    step(1'b0, 1'b1, 8'h40);
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL jump_flush got=%0d/%b exp=0/0", level, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step(1'b0, 1'b0, '0);
      if (out_valid) begin
        seen = 1'b1;
        checks++;
        if (out_pc !== 8'h40 || out_byte !== mem[8'h40]) begin
          failures++;
          $display("FAIL jump_first got=%h/%h exp=40/%h",
                   out_pc, out_byte, mem[8'h40]);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL jump_timeout got=invalid exp=valid");
    end
  endtask

  task automatic test_jump_consume();
    bit seen;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 8'h20);
    checks++;
    if (level !== 3'd0) begin
      failures++;
      $display("FAIL jc_flush got=%0d exp=0", level);
    end
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step(1'b0, 1'b0, '0);
      if (out_valid) begin
        seen = 1'b1;
        checks++;
        if (out_pc !== 8'h20) begin
          failures++;
          $display("FAIL jc_first got=%h exp=20", out_pc);
        end
      end
    end
    step(1'b1, 1'b1, 8'h20);
    step(1'b1, 1'b1, 8'h30);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        checks++;
        if (out_pc !== 8'h30 || out_byte !== mem[8'h30]) begin
          failures++;
          $display("FAIL jj_first got=%h/%h exp=30/%h",
                   out_pc, out_byte, mem[8'h30]);
        end
      end else begin
        step(1'b1, 1'b0, '0);
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL jj_timeout got=invalid exp=valid");
    end
    step(1'b1, 1'b0, '0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 8'h31) begin
      failures++;
      $display("FAIL jj_next got=%b/%h exp=1/31", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pc [4];
    int n;
    exp_pc[0] = 4'hE;
    exp_pc[1] = 4'hF;
    exp_pc[2] = 4'h0;
    exp_pc[3] = 4'h1;
    jump4      = 1'b1;
    jump_addr4 = 4'hE;
    consume4   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    jump4 = 1'b0;
    n = 0;
    for (int i = 0; i < 12 && n < 4; i++) begin
      if (out_valid4) begin
        checks++;
        if (out_pc4 !== exp_pc[n] ||
            out_byte4 !== ({4'h0, exp_pc[n]} + 8'h10)) begin
          failures++;
          $display("FAIL wrap_seq got=%h/%h exp=%h", out_pc4, out_byte4,
                   exp_pc[n]);
        end
        n++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    consume4 = 1'b0;
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL wrap_timeout got=%0d exp=4", n);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    checks++;
    if (level !== 3'd2) begin
      failures++;
      $display("FAIL ar_pre_level got=%0d exp=2", level);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0 || pm_addr !== 8'h00) begin
      failures++;
      $display("FAIL ar_async got=%0d/%b/%h exp=0/0/00",
               level, out_valid, pm_addr);
    end
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        checks++;
        if (out_pc !== 8'h00 || out_byte !== mem[0]) begin
          failures++;
          $display("FAIL ar_first got=%h/%h exp=00/%h",
                   out_pc, out_byte, mem[0]);
        end
      end else begin
        step(1'b1, 1'b0, '0);
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ar_timeout got=invalid exp=valid");
    end
  endtask

  task automatic test_random();
    bit c;
    bit j;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 400; n++) begin
      c = ($urandom_range(0, 3) != 0);
      j = ($urandom_range(0, 15) == 0);
      step(c, j, 8'($urandom));
      checks++;
      if (level !== 3'(q.size())) begin
        failures++;
        $display("FAIL rnd_level got=%0d exp=%0d", level, q.size());
      end
      checks++;
      if (out_valid !== (q.size() > 0)) begin
        failures++;
        $display("FAIL rnd_valid got=%b exp=%b", out_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (out_pc !== q[0] || out_byte !== mem[q[0]]) begin
          failures++;
          $display("FAIL rnd_head got=%h/%h exp=%h/%h",
                   out_pc, out_byte, q[0], mem[q[0]]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    test_reset();
    test_fill();
    test_wrap();
    test_stream();
    test_jump();
    test_jump_consume();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
